// File: rtl/pll_mgmt_responder_pkg.sv
// Shared addresses, frame layout and FSM encoding for the PLL management responder.
package pll_mgmt_pkg;

    localparam logic [5:0] ADDR_MODE   = 6'd0;
    localparam logic [5:0] ADDR_STATUS = 6'd1;
    localparam logic [5:0] ADDR_START  = 6'd2;
    localparam logic [5:0] ADDR_N      = 6'd3;
    localparam logic [5:0] ADDR_M      = 6'd4;
    localparam logic [5:0] ADDR_C      = 6'd5;
    localparam logic [5:0] ADDR_K      = 6'd7;
    localparam logic [5:0] ADDR_BW     = 6'd8;
    localparam logic [5:0] ADDR_CP     = 6'd9;

    localparam int FRAME_W = 96;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        UPDATE
    } fsm_state_t;

    typedef struct packed {
        logic [2:0]  cp;
        logic [3:0]  bw;
        logic [31:0] k;
        logic [17:0] c0;
        logic [17:0] m;
        logic [17:0] n;
    } pll_cfg_t;

    // Scan frame: three zero pad bits above the configuration fields, MSB shifted first.
    function automatic logic [FRAME_W-1:0] pack_frame(input pll_cfg_t c);
        return {3'b000, c};
    endfunction

endpackage

// File: rtl/pll_mgmt_responder_if.sv
// Avalon-MM management bus between the reconfiguration controller and the responder.
interface pll_mgmt_responder_if;

    logic [5:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, write, writedata, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, waitrequest
    );

endinterface

// File: rtl/pll_mgmt_responder_scan_shifter.sv
// Serialises a 96-bit frame MSB-first; each bit occupies 2*SCAN_HALF clocks, low half then high half.
module pll_scan_shifter
    import pll_mgmt_pkg::*;
#(
    parameter int SCAN_HALF = 2
) (
    input  logic               CLK_50M,
    input  logic               RESET,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               scan_clk,
    output logic               scan_data,
    output logic               done
);

    localparam int DIV_W = $clog2(2 * SCAN_HALF);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCAN_HALF - 1);
    localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'(SCAN_HALF - 1);
    localparam logic [6:0]       BIT_LAST = 7'(FRAME_W - 1);

    logic               active;
    logic [6:0]         bit_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [FRAME_W-1:0] frame_q;

    // High during the final clock of the final bit period.
    assign done = active & (div_cnt == DIV_LAST) & (bit_cnt == BIT_LAST);

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            active    <= 1'b0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            frame_q   <= '0;
            scan_clk  <= 1'b0;
            scan_data <= 1'b0;
        end else if (start) begin
            active    <= 1'b1;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            frame_q   <= frame;
            scan_clk  <= 1'b0;
            scan_data <= frame[FRAME_W-1];
        end else if (active) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt  <= '0;
                scan_clk <= 1'b0;
                if (bit_cnt == BIT_LAST) begin
                    active    <= 1'b0;
                    scan_data <= 1'b0;
                end else begin
                    bit_cnt   <= bit_cnt + 7'd1;
                    scan_data <= frame_q[7'(FRAME_W - 2) - bit_cnt];
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
                if (div_cnt == DIV_MID) begin
                    scan_clk <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pll_mgmt_responder.sv
// PLL management responder: shadow register file, waitrequest/polling handshake and apply sequencing.
// state  | meaning
// IDLE   | not busy, all requests served
// LOAD   | snapshot shadows into the pending config and the shifter
// SHIFT  | frame being serialised onto the scan chain
// UPDATE | scan_update and cfg_valid pulse, cfg_* carry the new set
module pll_mgmt_responder
    import pll_mgmt_pkg::*;
#(
    parameter int SCAN_HALF = 2
) (
    input  logic                CLK_50M,
    input  logic                RESET,
    pll_mgmt_responder_if.slave mgmt,
    output logic                scan_clk,
    output logic                scan_data,
    output logic                scan_update,
    output logic [17:0]         cfg_n,
    output logic [17:0]         cfg_m,
    output logic [17:0]         cfg_c0,
    output logic [31:0]         cfg_k,
    output logic [3:0]          cfg_bw,
    output logic [2:0]          cfg_cp,
    output logic                cfg_valid
);

    fsm_state_t  state_q, state_d;
    logic        mode_q;
    pll_cfg_t    shadow_q, pend_q;
    logic        busy, wr_en, start_go;
    logic        shift_start, shift_done, load_cfg;
    logic [31:0] rdata;

    assign busy             = (state_q != IDLE);
    assign mgmt.waitrequest = ~mode_q & busy & (mgmt.write | mgmt.read);
    // In polling mode only MODE writes land while busy; in stall mode busy writes never get here.
    assign wr_en    = mgmt.write & ~mgmt.waitrequest & (~busy | (mgmt.address == ADDR_MODE));
    assign start_go = wr_en & (mgmt.address == ADDR_START);

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_start = 1'b0;
        load_cfg    = 1'b0;
        case (state_q)
            IDLE:   if (start_go) state_d = LOAD;
            LOAD: begin
                shift_start = 1'b1;
                state_d     = SHIFT;
            end
            SHIFT: begin
                if (shift_done) begin
                    load_cfg = 1'b1;
                    state_d  = UPDATE;
                end
            end
            UPDATE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            mode_q   <= 1'b0;
            shadow_q <= '0;
            pend_q   <= '0;
        end else begin
            if (shift_start) begin
                pend_q <= shadow_q;
            end
            if (wr_en) begin
                case (mgmt.address)
                    ADDR_MODE: mode_q      <= mgmt.writedata[0];
                    ADDR_N:    shadow_q.n  <= mgmt.writedata[17:0];
                    ADDR_M:    shadow_q.m  <= mgmt.writedata[17:0];
                    ADDR_C: begin
                        if (mgmt.writedata[22:18] == 5'd0) begin
                            shadow_q.c0 <= mgmt.writedata[17:0];
                        end
                    end
                    ADDR_K:    shadow_q.k  <= mgmt.writedata;
                    ADDR_BW:   shadow_q.bw <= mgmt.writedata[3:0];
                    ADDR_CP:   shadow_q.cp <= mgmt.writedata[2:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            cfg_n       <= '0;
            cfg_m       <= '0;
            cfg_c0      <= '0;
            cfg_k       <= '0;
            cfg_bw      <= '0;
            cfg_cp      <= '0;
            cfg_valid   <= 1'b0;
            scan_update <= 1'b0;
        end else begin
            cfg_valid   <= load_cfg;
            scan_update <= load_cfg;
            if (load_cfg) begin
                cfg_n  <= pend_q.n;
                cfg_m  <= pend_q.m;
                cfg_c0 <= pend_q.c0;
                cfg_k  <= pend_q.k;
                cfg_bw <= pend_q.bw;
                cfg_cp <= pend_q.cp;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (mgmt.address)
            ADDR_MODE:   rdata[0]     = mode_q;
            ADDR_STATUS: rdata[0]     = ~busy;
            ADDR_N:      rdata[17:0]  = shadow_q.n;
            ADDR_M:      rdata[17:0]  = shadow_q.m;
            ADDR_C:      rdata[17:0]  = shadow_q.c0;
            ADDR_K:      rdata        = shadow_q.k;
            ADDR_BW:     rdata[3:0]   = shadow_q.bw;
            ADDR_CP:     rdata[2:0]   = shadow_q.cp;
            default:     rdata        = '0;
        endcase
    end

    assign mgmt.readdata = rdata;

    pll_scan_shifter #(
        .SCAN_HALF (SCAN_HALF)
    ) u_shifter (
        .CLK_50M   (CLK_50M),
        .RESET     (RESET),
        .start     (shift_start),
        .frame     (pack_frame(shadow_q)),
        .scan_clk  (scan_clk),
        .scan_data (scan_data),
        .done      (shift_done)
    );

endmodule

// File: tb/tb_pll_mgmt_responder.sv
// Bench for pll_mgmt_responder: directed and randomized bus traffic against a register-level model.
module tb_pll_mgmt_responder;
    import pll_mgmt_pkg::*;

    localparam int H        = 2;
    localparam int BUSY_CYC = 2 + 2 * FRAME_W * H;
    localparam int TIMEOUT  = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pll_mgmt_responder_if bus ();

    logic        scan_clk, scan_data, scan_update, cfg_valid;
    logic [17:0] cfg_n, cfg_m, cfg_c0;
    logic [31:0] cfg_k;
    logic [3:0]  cfg_bw;
    logic [2:0]  cfg_cp;

    pll_mgmt_responder #(.SCAN_HALF(H)) dut (
        .CLK_50M     (clk),
        .RESET       (rst),
        .mgmt        (bus),
        .scan_clk    (scan_clk),
        .scan_data   (scan_data),
        .scan_update (scan_update),
        .cfg_n       (cfg_n),
        .cfg_m       (cfg_m),
        .cfg_c0      (cfg_c0),
        .cfg_k       (cfg_k),
        .cfg_bw      (cfg_bw),
        .cfg_cp      (cfg_cp),
        .cfg_valid   (cfg_valid)
    );

    always #10 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   n_valid = 0;
    int   n_update = 0;
    logic prev_sclk = 1'b0;
    logic q_bits[$];

    // Scan-chain receiver: captures scan_data on each scan_clk rise, counts output pulses.
    always @(posedge clk) begin
        #2;
        if (scan_clk === 1'b1 && prev_sclk === 1'b0) q_bits.push_back(scan_data);
        prev_sclk = scan_clk;
        if (cfg_valid === 1'b1) n_valid++;
        if (scan_update === 1'b1) n_update++;
    end

    // Register-level model of the shadow set and mode bit.
    logic        m_mode;
    logic [17:0] m_n, m_m, m_c0;
    logic [31:0] m_k;
    logic [3:0]  m_bw;
    logic [2:0]  m_cp;

    function automatic void model_reset();
        m_mode = 1'b0; m_n = '0; m_m = '0; m_c0 = '0; m_k = '0; m_bw = '0; m_cp = '0;
    endfunction

    function automatic void model_write(input logic [5:0] a, input logic [31:0] d);
        case (a)
            6'd0: m_mode = d[0];
            6'd3: m_n    = d[17:0];
            6'd4: m_m    = d[17:0];
            6'd5: if (d[22:18] == 5'd0) m_c0 = d[17:0];
            6'd7: m_k    = d;
            6'd8: m_bw   = d[3:0];
            6'd9: m_cp   = d[2:0];
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [5:0] a, input logic busy);
        case (a)
            6'd0:    return {31'b0, m_mode};
            6'd1:    return {31'b0, ~busy};
            6'd3:    return {14'b0, m_n};
            6'd4:    return {14'b0, m_m};
            6'd5:    return {14'b0, m_c0};
            6'd7:    return m_k;
            6'd8:    return {28'b0, m_bw};
            6'd9:    return {29'b0, m_cp};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [95:0] model_frame();
        return {3'b000, m_cp, m_bw, m_k, m_c0, m_m, m_n};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus tasks start and end at a falling clock edge; stall counts cycles with waitrequest high.
    task automatic bus_wr(input logic [5:0] a, input logic [31:0] d, output int stall);
        stall = 0;
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        #1;
        while (bus.waitrequest !== 1'b0 && stall < TIMEOUT) begin
            @(negedge clk); #1; stall++;
        end
        chk("wr_no_timeout", stall < TIMEOUT, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic bus_rd(input logic [5:0] a, output logic [31:0] d, output int stall);
        stall = 0;
        bus.address = a; bus.read = 1'b1;
        #1;
        while (bus.waitrequest !== 1'b0 && stall < TIMEOUT) begin
            @(negedge clk); #1; stall++;
        end
        chk("rd_no_timeout", stall < TIMEOUT, 1'b1);
        d = bus.readdata;
        @(posedge clk);
        @(negedge clk);
        bus.read = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        int st;
        bus_wr(a, d, st);
        model_write(a, d);
    endtask

    task automatic check_bits(input string tag, input logic [95:0] exp);
        logic [95:0] got;
        got = '0;
        for (int i = 0; i < q_bits.size() && i < 96; i++) got[95-i] = q_bits[i];
        chk({tag, "_nbits"}, q_bits.size(), 96);
        chk({tag, "_bits"}, got, exp);
    endtask

    task automatic check_cfg(input string tag, input logic [95:0] exp);
        logic [92:0] e;
        e = exp[92:0];
        chk({tag, "_cfg"}, {cfg_cp, cfg_bw, cfg_k, cfg_c0, cfg_m, cfg_n}, e);
    endtask

    // Mode-0 apply: START, then a STATUS read that stalls for the whole busy window.
    task automatic run_apply(input string tag);
        logic [95:0] exp_f;
        logic [31:0] rd;
        int st, v0, u0;
        exp_f = model_frame();
        q_bits.delete();
        v0 = n_valid; u0 = n_update;
        bus_wr(ADDR_START, $urandom, st);
        chk({tag, "_start_nostall"}, st, 0);
        bus_rd(ADDR_STATUS, rd, st);
        chk({tag, "_busy_len"}, st, BUSY_CYC);
        chk({tag, "_status_idle"}, rd, 1);
        check_bits(tag, exp_f);
        chk({tag, "_valid_cnt"}, n_valid - v0, 1);
        chk({tag, "_update_cnt"}, n_update - u0, 1);
        check_cfg(tag, exp_f);
    endtask

    initial begin
        logic [31:0] rd, d;
        logic [95:0] f_old;
        int st, v0, guard;
        logic [5:0] a;

        bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
        model_reset();

        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_waitreq", bus.waitrequest, 1'b0);
        chk("rst_outputs", {scan_clk, scan_data, scan_update, cfg_valid}, 4'b0);
        chk("rst_cfg", {cfg_cp, cfg_bw, cfg_k, cfg_c0, cfg_m, cfg_n}, 93'b0);
        bus_rd(ADDR_STATUS, rd, st);
        chk("rst_status", rd, 1);
        chk("rst_status_nostall", st, 0);
        bus_rd(ADDR_K, rd, st);
        chk("rst_k", rd, 0);

        // Full apply with the reference values
        wr(ADDR_MODE, 32'h0);
        wr(ADDR_M, 32'h00404);
        wr(ADDR_K, 32'hF0A3D6B4);
        wr(ADDR_N, 32'h10000);
        wr(ADDR_C, 32'h20201);
        wr(ADDR_CP, 32'h1);
        wr(ADDR_BW, 32'h7);
        run_apply("apply1");
        chk("apply1_m", cfg_m, 18'h00404);
        chk("apply1_k", cfg_k, 32'hF0A3D6B4);

        // Stall: M write issued 10 cycles into the apply waits out the busy window
        f_old = model_frame();
        q_bits.delete();
        bus_wr(ADDR_START, 32'h0, st);
        repeat (9) @(negedge clk);
        bus_wr(ADDR_M, 32'h00505, st);
        chk("stall_len", st, BUSY_CYC - 9);
        chk("stall_cfg_m_old", cfg_m, 18'h00404);
        check_bits("stall", f_old);
        model_write(ADDR_M, 32'h00505);
        run_apply("apply2");
        chk("apply2_m", cfg_m, 18'h00505);

        // Randomized shadow traffic, readback and apply
        for (int it = 0; it < 4; it++) begin
            wr(ADDR_N, $urandom);
            wr(ADDR_M, $urandom);
            wr(ADDR_K, $urandom);
            wr(ADDR_BW, $urandom);
            wr(ADDR_CP, $urandom);
            d = $urandom;
            if (it % 2 == 0) d[22:18] = 5'd0;
            wr(ADDR_C, d);
            a = 6'($urandom_range(10, 63));
            wr(a, $urandom);
            wr(6'd6, $urandom);
            for (int r = 0; r < 10; r++) begin
                bus_rd(6'(r), rd, st);
                chk($sformatf("rand%0d_rd%0d", it, r), rd, model_read(6'(r), 1'b0));
            end
            run_apply($sformatf("rand%0d", it));
        end

        // Polling mode
        wr(ADDR_MODE, 32'h1);
        bus_rd(ADDR_MODE, rd, st);
        chk("poll_mode_rd", rd, 1);
        f_old = model_frame();
        q_bits.delete();
        v0 = n_valid;
        bus_wr(ADDR_START, 32'h0, st);
        repeat (100) @(negedge clk);
        bus_rd(ADDR_STATUS, rd, st);
        chk("poll_status_busy", rd, 0);
        chk("poll_rd_nostall", st, 0);
        bus_wr(ADDR_K, 32'h1234, st);
        chk("poll_wr_nostall", st, 0);
        bus_wr(ADDR_START, 32'h0, st);
        rd = 32'h0;
        guard = 0;
        while (rd !== 32'h1 && guard < 1000) begin
            bus_rd(ADDR_STATUS, rd, st);
            guard++;
        end
        chk("poll_done", rd, 1);
        repeat (400) @(negedge clk);
        chk("poll_one_apply", n_valid - v0, 1);
        check_bits("poll", f_old);
        check_cfg("poll", f_old);
        bus_rd(ADDR_K, rd, st);
        chk("poll_k_kept", rd, m_k);

        // Reset in the middle of a shift
        q_bits.delete();
        bus_wr(ADDR_START, 32'h0, st);
        guard = 0;
        while (q_bits.size() < 40 && guard < TIMEOUT) begin
            @(negedge clk);
            guard++;
        end
        chk("rstmid_reach_bit40", q_bits.size() >= 40, 1'b1);
        v0 = n_valid;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_outputs", {scan_clk, scan_data, scan_update, cfg_valid}, 4'b0);
        rst = 1'b0;
        model_reset();
        repeat (400) @(negedge clk);
        chk("rstmid_no_valid", n_valid - v0, 0);
        chk("rstmid_cfg", {cfg_cp, cfg_bw, cfg_k, cfg_c0, cfg_m, cfg_n}, 93'b0);
        bus_rd(ADDR_STATUS, rd, st);
        chk("rstmid_status", rd, 1);
        bus_rd(ADDR_MODE, rd, st);
        chk("rstmid_mode", rd, 0);

        // Address decode and C counter select
        wr(ADDR_C, 32'h00ABC);
        wr(6'd6, 32'hFFFFFFFF);
        wr(ADDR_C, 32'h40123);
        bus_rd(6'd6, rd, st);
        chk("dec_rd6", rd, 0);
        bus_rd(ADDR_C, rd, st);
        chk("dec_c_kept", rd, model_read(ADDR_C, 1'b0));
        chk("dec_c_val", rd, 32'h00ABC);
        bus_rd(ADDR_START, rd, st);
        chk("dec_rd_start", rd, 0);
        bus_rd(6'd63, rd, st);
        chk("dec_rd63", rd, 0);
        run_apply("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_mgmt_responder.md
Name: pll_mgmt_responder

Overview:
- Avalon-MM responder on the PLL reconfiguration management bus, sitting at the slave end of the mgmt_* interface.
- Holds shadow M/N/K/C0/bandwidth/charge-pump registers written by the controller.
- On a START write, serialises the shadow set into a scan frame for the PLL reconfiguration chain, then publishes the applied configuration.
- Provides waitrequest and polling handshake modes.

Parameters:
SCAN_HALF, 2, CLK_50M cycles per scan_clk half-period (≥1)

Ports:
CLK_50M  in  1  system clock
RESET  in  1  reset, synchronous, active-high
mgmt_address  in  6  register address
mgmt_write  in  1  write request
mgmt_writedata  in  32  write data
mgmt_read  in  1  read request
mgmt_readdata  out  32  read data, valid in accept cycle
mgmt_waitrequest  out  1  stall; request accepted when low
scan_clk  out  1  scan chain clock
scan_data  out  1  scan chain data, MSB first
scan_update  out  1  one-cycle pulse after last bit
cfg_n  out  18  applied N
cfg_m  out  18  applied M
cfg_c0  out  18  applied C0
cfg_k  out  32  applied fractional K
cfg_bw  out  4  applied bandwidth
cfg_cp  out  3  applied charge pump
cfg_valid  out  1  one-cycle pulse when cfg_* updated

Behaviour:
- Clocking and reset: clock CLK_50M; reset RESET, synchronous, active-high.
- Reset values: all shadows and cfg_* are 0, mode=0, FSM IDLE; scan_clk, scan_data, scan_update, cfg_valid and mgmt_waitrequest are 0.
- Register map (W = write, R = read):
  - 0 MODE: W/R, bit0 (0 = waitrequest mode, 1 = polling mode).
  - 1 STATUS: R only, bit0 = ~busy.
  - 2 START: W only, data ignored.
  - 3 N, 4 M: W/R, bits 17:0.
  - 5 C: W/R. Bits 22:18 are the counter select; a write is taken only when select == 0, and otherwise ignored. Bits 17:0 go to the shadow.
  - 7 K: W/R, bits 31:0.
  - 8 BW: W/R, bits 3:0.
  - 9 CP: W/R, bits 2:0.
  - All other addresses: writes ignored, reads return 0. Unused high bits read 0.
- Handshake:
  - mgmt_waitrequest = (mode==0) & busy & (mgmt_write|mgmt_read). It is combinational from the registered busy flag.
  - Accept occurs when a request is high and waitrequest is low. Writes take effect at the clock edge. mgmt_readdata is combinational from the registers during the accept cycle. write and read high together is treated as a write.
  - Polling mode: waitrequest is never asserted. While busy, all writes except MODE are dropped; reads are always served.
- FSM:
  - IDLE -> LOAD on an accepted START write; busy=1 from the next cycle.
  - LOAD (1 cycle): latch frame = {3'b000, cp, bw, k, c0, m, n} (96 bits). Clear bit_cnt and div_cnt.
  - SHIFT: each bit period is 2*SCAN_HALF cycles. scan_data is driven with frame[95-bit_cnt] at the period start. scan_clk is low for the first SCAN_HALF cycles and high for the second. After period 95 ends, go to UPDATE with scan_clk low.
  - UPDATE (1 cycle): scan_update=1, cfg_valid=1, cfg_* <= latched frame fields. Next state IDLE with busy=0.
  - Busy spans from the cycle after accept through UPDATE inclusive: 1 + 96*2*SCAN_HALF + 1 cycles (386 at default).
- Boundary cases:
  - Shadow writes during shift (accepted only in mode 0 after the stall, or in mode 1 via MODE) do not affect the frame in flight.
  - START while busy: mode 0 stalls until IDLE, then starts a fresh apply. Mode 1 drops it.
  - RESET mid-operation forces IDLE the next cycle, with no scan_update/cfg_valid and scan outputs at 0.
  - bit_cnt is 7 bits and never wraps past 95.

Decomposition:
- Package pll_mgmt_pkg holds:
  - address localparams (ADDR_MODE=0, ADDR_STATUS=1, ADDR_START=2, ADDR_N=3, ADDR_M=4, ADDR_C=5, ADDR_K=7, ADDR_BW=8, ADDR_CP=9);
  - FRAME_W=96;
  - the FSM state enum (IDLE, LOAD, SHIFT, UPDATE);
  - a packed struct for the frame fields.
- One natural sub-module: pll_scan_shifter. It takes a 96-bit parallel load plus start, and produces scan_clk, scan_data, done. It owns bit_cnt and div_cnt.
- The register file and handshake stay in the top module.

Test Plan:
- Reset: assert RESET 2 cycles, then read addr 1 -> readdata=1, waitrequest=0, all cfg_*=0, scan_clk=0.
- Full apply: mode 0 writes 0->0, 4->0x00404, 7->0xF0A3D6B4, 3->0x10000, 5->0x20201, 9->1, 8->7, then write 2 -> busy for 386 cycles. The 96 sampled bits on scan_clk rising edges equal the frame MSB-first. One cfg_valid pulse, with cfg_m=0x00404, cfg_k=0xF0A3D6B4, cfg_n=0x10000, cfg_c0=0x20201, cfg_bw=7, cfg_cp=1.
- Stall: write 4->0x00505 at 10 cycles after START -> waitrequest held high until the cycle after UPDATE, then accepted. cfg_m stays 0x00404; a second START yields cfg_m=0x00505.
- Polling: write 0->1, START, read addr 1 mid-shift -> readdata=0 and waitrequest=0. A write 7->0x1234 during busy is dropped, so a read of addr 7 after completion returns the old K.
- Reset mid-shift: RESET at bit 40 -> scan_clk=0 and scan_data=0 next cycle, no cfg_valid, STATUS reads 1.
- Decode: write 6->0xFFFFFFFF and 5->0x40123 (select=1) -> both ignored; read 6 -> 0, read 5 -> prior C value.
